// File: rtl/mem_bus_master_if.sv
// Command/response and memory-bus signal bundle for mem_bus_master.
// master = bus initiator side, slave = CPU/memory environment side.
interface mem_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] addrs_bus;
  logic        request;
  logic        rw;
  logic [15:0] data_bus_write;
  logic [15:0] data_bus_read;
  logic        wait_;

  modport master (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_rw,
    input  cmd_addr,
    input  cmd_wdata,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output addrs_bus,
    output request,
    output rw,
    output data_bus_write,
    input  data_bus_read,
    input  wait_
  );

  modport slave (
    output cmd_valid,
    input  cmd_ready,
    output cmd_rw,
    output cmd_addr,
    output cmd_wdata,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  addrs_bus,
    input  request,
    input  rw,
    input  data_bus_write,
    output data_bus_read,
    output wait_
  );
endinterface

// File: rtl/mem_bus_master.sv
// Word-wide request/wait_ bus initiator: one command at a time,
// full four-phase handshake with per-phase timeout, then one-cycle response.
module mem_bus_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL,
    RESP
  } state_e;

  localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            err_q;
  logic [15:0]     rdata_q;
  logic [15:0]     addr_q;
  logic [15:0]     wdata_q;
  logic            req_q;
  logic            rw_q;
  logic            rdy_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [15:0]     rsp_rdata_q;
  logic            to_hit;
  logic            rel_err;

  assign to_hit  = TO_EN && (cnt_q == TO_LAST);
  // A release phase that ends by timeout (wait_ still low) is an error too.
  assign rel_err = err_q | ~bus.wait_;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      rw_q        <= 1'b1;
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            rw_q    <= bus.cmd_rw;
            wdata_q <= bus.cmd_wdata;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!bus.wait_) begin
            rdata_q <= rw_q ? bus.data_bus_read : 16'h0000;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= REL;
          end else if (to_hit) begin
            rdata_q <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= REL;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        REL: begin
          if (bus.wait_ || to_hit) begin
            err_q       <= rel_err;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rel_err;
            rsp_rdata_q <= rel_err ? 16'h0000 : rdata_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rw_q        <= 1'b1;
          rdy_q       <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = rdy_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.addrs_bus      = addr_q;
  assign bus.request        = req_q;
  assign bus.rw             = rw_q;
  assign bus.data_bus_write = wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed + randomized bench for mem_bus_master with a byte-wide
// big-endian memory model and an independent reference image.
module tb_mem_bus_master;

  logic clk;
  logic reset;

  mem_bus_master_if bus ();

  mem_bus_master #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  int          mode;
  int          lat_cfg;
  int          lat_cnt;
  logic        req_prev;
  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_rw;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: mode 0 acks after lat_cfg cycles, 1 never acks, 2 never releases.
  always @(negedge clk) begin
    if (reset) begin
      bus.wait_ = 1'b1;
      lat_cnt   = 0;
      req_prev  = 1'b0;
    end else begin
      if (bus.request && !req_prev) begin
        cap_addr  = bus.addrs_bus;
        cap_wdata = bus.data_bus_write;
        cap_rw    = bus.rw;
      end else if (bus.request) begin
        chk("bus_addr_stable", 32'(bus.addrs_bus), 32'(cap_addr));
        chk("bus_rw_stable", 32'(bus.rw), 32'(cap_rw));
        chk("bus_wdata_stable", 32'(bus.data_bus_write), 32'(cap_wdata));
      end
      req_prev = bus.request;
      if (bus.request && bus.wait_) begin
        if (mode != 1) begin
          if (lat_cnt < lat_cfg) begin
            lat_cnt++;
          end else begin
            lat_cnt   = 0;
            bus.wait_ = 1'b0;
            if (bus.rw) begin
              bus.data_bus_read = {mem[bus.addrs_bus],
                                   mem[16'(bus.addrs_bus + 16'd1)]};
            end else begin
              mem[bus.addrs_bus]                = bus.data_bus_write[15:8];
              mem[16'(bus.addrs_bus + 16'd1)]   = bus.data_bus_write[7:0];
            end
          end
        end
      end else if (!bus.request && !bus.wait_ && mode != 2) begin
        bus.wait_ = 1'b1;
      end
    end
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return {ref_mem[a], ref_mem[16'(a + 16'd1)]};
  endfunction

  task automatic ref_wr(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a]              = d[15:8];
    ref_mem[16'(a + 16'd1)] = d[7:0];
  endtask

  task automatic run_cmd(input logic rw, input logic [15:0] a,
                         input logic [15:0] wd, output logic [15:0] rd,
                         output logic er, output int lat, output int reqc);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat  = 0;
    reqc = 0;
    rd   = 'x;
    er   = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.request) reqc++;
      if (bus.rsp_valid) begin
        lat = i;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
    chk("rsp_seen", 32'(lat != 0), 32'd1);
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] rd,
                           input logic er, input int lat, input int reqc,
                           input logic [15:0] exp_rd, input logic exp_er,
                           input int exp_lat, input int exp_reqc);
    chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_reqc"}, 32'(reqc), 32'(exp_reqc));
    chk({tag, "_hold"}, 32'(bus.rsp_rdata), 32'(exp_rd));
    chk({tag, "_rw_idle"}, 32'(bus.rw), 32'd1);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] rd1;
    logic        er;
    logic        er1;
    logic        rw;
    int          lat;
    int          reqc;
    int          first_rsp;
    int          req2;
    int          rsp2;
    int          seen;

    tests = 0;
    fails = 0;
    mode    = 0;
    lat_cfg = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0080] = 8'hAB;
    mem[16'h0081] = 8'hCD;
    ref_mem[16'h0080] = 8'hAB;
    ref_mem[16'h0081] = 8'hCD;

    bus.cmd_valid     = 1'b0;
    bus.cmd_rw        = 1'b1;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.data_bus_read = '0;
    bus.wait_         = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_request", 32'(bus.request), 32'd0);
    chk("rst_rw", 32'(bus.rw), 32'd1);
    chk("rst_addr", 32'(bus.addrs_bus), 32'd0);
    chk("rst_wdata", 32'(bus.data_bus_write), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(1'b1, 16'h0080, 16'h0000, rd, er, lat, reqc);
    check_rsp("read80", rd, er, lat, reqc, 16'hABCD, 1'b0, 3, 1);

    run_cmd(1'b0, 16'h0084, 16'hABCE, rd, er, lat, reqc);
    ref_wr(16'h0084, 16'hABCE);
    check_rsp("write84", rd, er, lat, reqc, 16'h0000, 1'b0, 3, 1);
    run_cmd(1'b1, 16'h0084, 16'h0000, rd, er, lat, reqc);
    check_rsp("readback84", rd, er, lat, reqc, 16'hABCE, 1'b0, 3, 1);

    mode = 1;
    run_cmd(1'b1, 16'h0080, 16'h0000, rd, er, lat, reqc);
    check_rsp("req_timeout_rd", rd, er, lat, reqc, 16'h0000, 1'b1, 18, 16);
    run_cmd(1'b0, 16'h0088, 16'h1234, rd, er, lat, reqc);
    check_rsp("req_timeout_wr", rd, er, lat, reqc, 16'h0000, 1'b1, 18, 16);
    mode = 0;
    run_cmd(1'b1, 16'h0088, 16'h0000, rd, er, lat, reqc);
    check_rsp("no_write_on_to", rd, er, lat, reqc, ref_rd(16'h0088),
              1'b0, 3, 1);

    mode = 2;
    run_cmd(1'b1, 16'h0080, 16'h0000, rd, er, lat, reqc);
    check_rsp("rel_timeout", rd, er, lat, reqc, 16'h0000, 1'b1, 18, 1);
    mode = 0;
    run_cmd(1'b1, 16'h0080, 16'h0000, rd, er, lat, reqc);
    check_rsp("after_stuck", rd, er, lat, reqc, 16'hABCD, 1'b0, 3, 1);

    // Back-to-back with cmd_valid held: second accepted at E4.
    wd = 16'($urandom);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 16'h0082;
    @(posedge clk);
    #1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 16'h0086;
    bus.cmd_wdata = wd;
    first_rsp = 0;
    req2      = 0;
    rsp2      = 0;
    rd1       = 'x;
    er1       = 1'bx;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n > 1 && bus.request && req2 == 0) begin
        req2 = n;
        bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid && first_rsp == 0) begin
        first_rsp = n;
        rd1 = bus.rsp_rdata;
        er1 = bus.rsp_err;
      end else if (bus.rsp_valid) begin
        rsp2 = n;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_rsp1_cycle", 32'(first_rsp), 32'd3);
    chk("b2b_rsp1_rdata", 32'(rd1), 32'(ref_rd(16'h0082)));
    chk("b2b_rsp1_err", 32'(er1), 32'd0);
    chk("b2b_req2_cycle", 32'(req2), 32'd5);
    chk("b2b_rsp2_cycle", 32'(rsp2), 32'd7);
    chk("b2b_rsp2_err", 32'(bus.rsp_err), 32'd0);
    ref_wr(16'h0086, wd);
    run_cmd(1'b1, 16'h0086, 16'h0000, rd, er, lat, reqc);
    check_rsp("b2b_readback", rd, er, lat, reqc, wd, 1'b0, 3, 1);

    // Reset in the middle of a request phase.
    mode = 1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 16'h0090;
    bus.cmd_wdata = 16'h5A5A;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_request", 32'(bus.request), 32'd1);
    chk("pre_rst_rw", 32'(bus.rw), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_request", 32'(bus.request), 32'd0);
    chk("mid_rst_rw", 32'(bus.rw), 32'd1);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    mode  = 0;
    seen  = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.request) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // Randomized traffic against the reference image.
    for (int k = 0; k < 40; k++) begin
      rw      = 1'($urandom);
      a       = 16'($urandom);
      wd      = 16'($urandom);
      lat_cfg = int'($urandom_range(0, 3));
      run_cmd(rw, a, wd, rd, er, lat, reqc);
      if (rw) begin
        check_rsp("rand_rd", rd, er, lat, reqc, ref_rd(a), 1'b0,
                  3 + lat_cfg, 1 + lat_cfg);
      end else begin
        ref_wr(a, wd);
        check_rsp("rand_wr", rd, er, lat, reqc, 16'h0000, 1'b0,
                  3 + lat_cfg, 1 + lat_cfg);
      end
    end
    lat_cfg = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
